pcie_pack_fifo: RTL
===================

# pcie_pack_fifo

Single-clock, parametrised width-packing prefetch FIFO for the PCIe DMA path. Narrow input words (e.g. 16-bit video pixels) are packed LSB-first into wide output words (e.g. 128-bit TLP payload beats), stored in an internal circular buffer and presented first-word-fall-through. It adds a flush command that emits a zero-padded partial word with a lane count, a fill-level output and a sticky overflow flag.

## Interface
- IN_WIDTH, 16, input word width; OUT_WIDTH must be an integer multiple of it.
- OUT_WIDTH, 128, output word width.
- DEPTH_WIDTH, 9, log2 of the output-word capacity (2^DEPTH_WIDTH words, prefetch register included).
- RATIO (derived), OUT_WIDTH/IN_WIDTH, a power of 2 that is at least 1. LANE_W = clog2(RATIO)+1.

Ports:
- clk  in  1  single clock; everything is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  input word strobe.
- wr_data  in  IN_WIDTH  input word.
- wr_vld  out  1  write side can accept: level != 2^DEPTH_WIDTH (combinational from registered level).
- flush  in  1  pad and push the partial word.
- rd_en  in  1  pop; honoured only while rd_vld=1.
- rd_vld  out  1  rd_data holds a valid word.
- rd_data  out  OUT_WIDTH  head word (FWFT).
- rd_lanes  out  LANE_W  valid input lanes in rd_data, 1..RATIO.
- level  out  DEPTH_WIDTH+1  words held, 0..2^DEPTH_WIDTH.
- ovf  out  1  sticky: a write or flush was dropped.

## Operation
- **Packer.** A lane counter k (0..RATIO-1) and a shift register.
  - An accepted write places wr_data in lane k, at bits [k*IN_WIDTH +: IN_WIDTH], then k increments.
  - When the word completes (k reaches RATIO), it is pushed with lanes=RATIO and k returns to 0.
- **Acceptance.** wr_en and flush are accepted only when wr_vld=1.
  - When wr_vld=0, wr_en and flush are dropped and ovf is set.
  - ovf is cleared only by reset.
- **Flush.**
  - If lanes are pending, the word is pushed with upper lanes zero, lanes=pending count, and k is set to 0. Pending lanes include a write accepted in the same cycle.
  - If a same-cycle write completes a full word, only that full word is pushed; there is no extra push.
  - If no lanes are pending, flush is a no-op.
- **RATIO=1.** Every write pushes immediately and flush is always a no-op.
- **Storage.**
  - Circular RAM with DEPTH_WIDTH-bit read and write pointers that wrap modulo 2^DEPTH_WIDTH.
  - A prefetch output register feeds rd_data and rd_lanes.
  - level counts the RAM entries plus the prefetch register.
- **Read.**
  - rd_en && rd_vld pops the head word; the next word is loaded into the prefetch register at the same edge if one is available.
  - Otherwise rd_vld falls and rd_data holds its last value.
  - rd_en while rd_vld=0 is ignored and has no side effect.
- **Simultaneous push and pop.** level is unchanged and there is no bubble.
- **Full.** The wr_vld decision is made on the registered level, so a pop in the same cycle does not admit a write.
- **Reset (rst_n low, immediate).**
  - rd_vld=0, rd_data=0, rd_lanes=0, level=0, ovf=0.
  - Pointers and k are 0 and pending lanes are discarded.
  - wr_vld=1.
  - RAM contents are don't-care and never surface.

## Timing
- **Push latency.** A push occurs at the edge sampling the completing write or flush (edge E).
  - With the FIFO empty, rd_vld=1 and rd_data are valid after edge E+1.
  - level increments after edge E.
- **Pop.** The pop is sampled at edge P. The new head, or rd_vld=0, is valid after edge P.
- **Throughput.** One write per clock; one output word per RATIO clocks; sustained with no drops when reads keep up.
- **Flow control.** wr_vld falls after the edge where level reaches 2^DEPTH_WIDTH and rises after the edge where a pop lowers it.

## Test plan
1. **Basic packing.** IN_WIDTH=16, OUT_WIDTH=128; write 0x0001..0x0008 on consecutive clocks.
   - rd_vld=1 two edges after the 8th write.
   - rd_data=0x0008_0007_0006_0005_0004_0003_0002_0001, rd_lanes=8, level=1.
2. **Partial flush.** Write 0x00A1, 0x00A2, 0x00A3, then flush.
   - rd_data=0x…0000_00A3_00A2_00A1 (upper 80 bits zero), rd_lanes=3.
   - A second flush with the packer empty produces no push; level is unchanged.
3. **Full and overflow.** DEPTH_WIDTH=4; write 128 words with no reads.
   - level=16, wr_vld=0.
   - A 129th write is dropped, ovf=1.
   - Popping 16 words returns them in order, lanes=8 each; ovf stays 1.
4. **Streaming with wrap.** Run continuous wr_en and rd_en whenever rd_vld, for 1000 input words with DEPTH_WIDTH=4.
   - Data matches in order and there are no drops.
   - level ≤ 2 throughout; pointers wrap at least 7 times.
5. **Reset mid-operation.** With 5 lanes pending and 3 words stored, pulse rst_n low between edges.
   - Outputs are zero immediately.
   - After release, 8 writes yield exactly one word with rd_lanes=8 and no stale data.
6. **RATIO=1.** IN_WIDTH=OUT_WIDTH=32; write 0xDEADBEEF with a flush in the same cycle.
   - One word is pushed, rd_lanes=1, rd_data=0xDEADBEEF.
   - level=1; no second push.

Source files
------------

// File: rtl/pcie_pack_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pcie_pack_fifo
//  Brief    : Width-packing first-word-fall-through FIFO for the PCIe DMA
//             path. Narrow input words are packed LSB-first into wide output
//             words and buffered in a circular RAM behind a prefetch register.
//             A flush pushes a zero-padded partial word with its lane count.
//  Revision : 1.0 - initial release
// ============================================================================
module pcie_pack_fifo #(
  parameter int IN_WIDTH    = 16,
  parameter int OUT_WIDTH   = 128,
  parameter int DEPTH_WIDTH = 9
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  wr_en,
  input  logic [IN_WIDTH-1:0]                   wr_data,
  output logic                                  wr_vld,
  input  logic                                  flush,
  input  logic                                  rd_en,
  output logic                                  rd_vld,
  output logic [OUT_WIDTH-1:0]                  rd_data,
  output logic [$clog2(OUT_WIDTH/IN_WIDTH):0]   rd_lanes,
  output logic [DEPTH_WIDTH:0]                  level,
  output logic                                  ovf
);

  localparam int RATIO   = OUT_WIDTH / IN_WIDTH;
  localparam int LANE_W  = $clog2(RATIO) + 1;
  localparam int LVL_W   = DEPTH_WIDTH + 1;
  localparam int CAP     = 1 << DEPTH_WIDTH;
  localparam int ENTRY_W = OUT_WIDTH + LANE_W;

  // Packer state: lanes collected so far and the partially built word.
  // r_shift keeps every lane at or above r_k at zero so a flushed word is
  // already padded.
  logic [LANE_W-1:0]      r_k;
  logic [OUT_WIDTH-1:0]   r_shift;

  // Storage state
  logic [ENTRY_W-1:0]     mem [CAP];
  logic [DEPTH_WIDTH-1:0] r_wptr;
  logic [DEPTH_WIDTH-1:0] r_rptr;
  logic [LVL_W-1:0]       r_level;
  logic                   r_vld;
  logic [OUT_WIDTH-1:0]   r_rd_data;
  logic [LANE_W-1:0]      r_rd_lanes;
  logic                   r_ovf;

  // Combinational control
  logic                   w_full;
  logic                   w_acc_wr;
  logic                   w_acc_fl;
  logic [LANE_W-1:0]      w_cnt;
  logic [OUT_WIDTH-1:0]   w_word;
  logic                   w_push;
  logic                   w_pop;
  logic [LVL_W-1:0]       w_ram_cnt;
  logic                   w_load;

  // Full is judged on the registered level only, so a pop in the same cycle
  // never opens the write side early.
  assign w_full   = (r_level == LVL_W'(CAP));
  assign wr_vld   = ~w_full;
  assign w_acc_wr = wr_en & ~w_full;
  assign w_acc_fl = flush & ~w_full;

  // Pending lane count including a write accepted this cycle.
  assign w_cnt    = r_k + LANE_W'(w_acc_wr);

  // A completed word wins over a flush; a flush with nothing pending is a no-op.
  assign w_push   = (w_cnt == LANE_W'(RATIO)) | (w_acc_fl & (w_cnt != '0));

  // Merge the incoming word into lane r_k of the word under construction.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    assign w_word[gi*IN_WIDTH +: IN_WIDTH] =
      (w_acc_wr && (r_k == LANE_W'(gi))) ? wr_data
                                          : r_shift[gi*IN_WIDTH +: IN_WIDTH];
  end

  // RAM occupancy excludes whatever sits in the prefetch register.
  assign w_pop     = rd_en & r_vld;
  assign w_ram_cnt = r_level - LVL_W'(r_vld);
  assign w_load    = (w_ram_cnt != '0) & (~r_vld | w_pop);

  // Packer: accumulate lanes, clear after every push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k     <= '0;
      r_shift <= '0;
    end else if (w_push) begin
      r_k     <= '0;
      r_shift <= '0;
    end else begin
      r_k     <= w_cnt;
      r_shift <= w_word;
    end
  end

  // Circular RAM write port; contents need no reset since reads are gated by level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem[r_wptr] <= {w_cnt, w_word};
    end
  end

  // Pointers, level and the prefetch output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_vld      <= 1'b0;
      r_rd_data  <= '0;
      r_rd_lanes <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + DEPTH_WIDTH'(1);
      end
      if (w_load) begin
        {r_rd_lanes, r_rd_data} <= mem[r_rptr];
        r_rptr                  <= r_rptr + DEPTH_WIDTH'(1);
        r_vld                   <= 1'b1;
      end else if (w_pop) begin
        r_vld <= 1'b0;
      end
      r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
    end
  end

  // Sticky overflow: any write or flush presented while full was dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if ((wr_en | flush) & w_full) begin
      r_ovf <= 1'b1;
    end
  end

  assign rd_vld   = r_vld;
  assign rd_data  = r_rd_data;
  assign rd_lanes = r_rd_lanes;
  assign level    = r_level;
  assign ovf      = r_ovf;

endmodule
`default_nettype wire
